// File: rtl/mips_alu_pkg.sv
// Shared definitions for the MIPS execute-stage ALU slice.
// The optional SLTU operation is enabled by defining ALU_SLTU_EN.
package mips_alu_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int REG_AW_DEF = 5;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_ADDU = 4'b0100;
  localparam logic [3:0] ALU_SUBU = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLTU = 4'b1000;
  localparam logic [3:0] ALU_LUI  = 4'b1001;
  localparam logic [3:0] ALU_NOR  = 4'b1100;

endpackage

// File: rtl/mips_alu_if.sv
// Bus bundle between the decode/control logic and the execute-stage ALU slice.
interface mips_alu_if #(
  parameter int DATA_W = mips_alu_pkg::DATA_W_DEF,
  parameter int REG_AW = mips_alu_pkg::REG_AW_DEF
);
  logic [3:0]        alu_ctrl;
  logic              alu_src;
  logic              reg_dst;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic [DATA_W-1:0] sign_ext;
  logic [REG_AW-1:0] rt_addr;
  logic [REG_AW-1:0] rd_addr;
  logic              status_we;
  logic [DATA_W-1:0] alu_result;
  logic              carry;
  logic              overflow;
  logic              zero;
  logic [REG_AW-1:0] write_reg;
  logic              carry_q;
  logic              overflow_q;
  logic              zero_q;
  logic              overflow_sticky;

  modport master (
    output alu_ctrl, alu_src, reg_dst, rs_data, rt_data, sign_ext,
           rt_addr, rd_addr, status_we,
    input  alu_result, carry, overflow, zero, write_reg,
           carry_q, overflow_q, zero_q, overflow_sticky
  );

  modport slave (
    input  alu_ctrl, alu_src, reg_dst, rs_data, rt_data, sign_ext,
           rt_addr, rd_addr, status_we,
    output alu_result, carry, overflow, zero, write_reg,
           carry_q, overflow_q, zero_q, overflow_sticky
  );
endinterface

// File: rtl/mips_alu_core.sv
// Combinational MIPS ALU producing result, carry and signed-overflow flags.
// SLTU (code 1000) exists only when ALU_SLTU_EN is defined.
module mips_alu_core
  import mips_alu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [3:0]        ctrl,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic              carry,
  output logic              overflow
);

`ifdef ALU_SLTU_EN
  localparam bit SLTU_EN = 1'b1;
`else
  localparam bit SLTU_EN = 1'b0;
`endif

  localparam int MSB = DATA_W - 1;

  logic [DATA_W:0] add_ext;
  logic [DATA_W:0] sub_ext;
  logic            add_ovf;
  logic            sub_ovf;
  logic            slt_bit;

  // One adder for A+B and one for A+~B+1 feed every arithmetic op.
  assign add_ext = {1'b0, a} + {1'b0, b};
  assign sub_ext = {1'b0, a} + {1'b0, ~b} + {{DATA_W{1'b0}}, 1'b1};
  assign add_ovf = (a[MSB] == b[MSB]) && (add_ext[MSB] != a[MSB]);
  assign sub_ovf = (a[MSB] != b[MSB]) && (sub_ext[MSB] != a[MSB]);
  // Correct signed compare even when the subtraction overflows.
  assign slt_bit = sub_ext[MSB] ^ sub_ovf;

  // Operation select; unused codes leave the all-zero defaults.
  always_comb begin
    result   = {DATA_W{1'b0}};
    carry    = 1'b0;
    overflow = 1'b0;
    case (ctrl)
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_XOR:  result = a ^ b;
      ALU_NOR:  result = ~(a | b);
      ALU_LUI:  result = b << 32'd16;
      ALU_ADD: begin
        result   = add_ext[MSB:0];
        carry    = add_ext[DATA_W];
        overflow = add_ovf;
      end
      ALU_ADDU: begin
        result = add_ext[MSB:0];
        carry  = add_ext[DATA_W];
      end
      ALU_SUB: begin
        result   = sub_ext[MSB:0];
        carry    = sub_ext[DATA_W];
        overflow = sub_ovf;
      end
      ALU_SUBU: begin
        result = sub_ext[MSB:0];
        carry  = sub_ext[DATA_W];
      end
      ALU_SLT: begin
        result = {{(DATA_W-1){1'b0}}, slt_bit};
        carry  = sub_ext[DATA_W];
      end
      ALU_SLTU: begin
        if (SLTU_EN) begin
          result = {{(DATA_W-1){1'b0}}, ~sub_ext[DATA_W]};
          carry  = sub_ext[DATA_W];
        end else begin
          result = {DATA_W{1'b0}};
          carry  = 1'b0;
        end
      end
      default: begin
        result   = {DATA_W{1'b0}};
        carry    = 1'b0;
        overflow = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mips_alu_datapath.sv
// Execute-stage slice: B-operand and destination muxes, ALU, and flag status register.
// Define ALU_SLTU_EN to enable the SLTU operation in the ALU core.
module mips_alu_datapath
  import mips_alu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic        clock,
  input  logic        reset,
  mips_alu_if.slave   bus
);

  logic [DATA_W-1:0] operand_b;
  logic [DATA_W-1:0] result;
  logic              carry;
  logic              overflow;
  logic              zero;
  logic              carry_q;
  logic              overflow_q;
  logic              zero_q;
  logic              overflow_sticky;

  assign operand_b = bus.alu_src ? bus.sign_ext : bus.rt_data;

  mips_alu_core #(.DATA_W(DATA_W)) u_core (
    .ctrl     (bus.alu_ctrl),
    .a        (bus.rs_data),
    .b        (operand_b),
    .result   (result),
    .carry    (carry),
    .overflow (overflow)
  );

  assign zero = (result == {DATA_W{1'b0}});

  // Flag capture; reset wins over status_we, and the sticky bit only accumulates.
  always_ff @(posedge clock) begin
    if (reset) begin
      carry_q         <= 1'b0;
      overflow_q      <= 1'b0;
      zero_q          <= 1'b0;
      overflow_sticky <= 1'b0;
    end else if (bus.status_we) begin
      carry_q         <= carry;
      overflow_q      <= overflow;
      zero_q          <= zero;
      overflow_sticky <= overflow_sticky | overflow;
    end else begin
      carry_q         <= carry_q;
      overflow_q      <= overflow_q;
      zero_q          <= zero_q;
      overflow_sticky <= overflow_sticky;
    end
  end

  assign bus.alu_result      = result;
  assign bus.carry           = carry;
  assign bus.overflow        = overflow;
  assign bus.zero            = zero;
  assign bus.write_reg       = bus.reg_dst ? bus.rd_addr : bus.rt_addr;
  assign bus.carry_q         = carry_q;
  assign bus.overflow_q      = overflow_q;
  assign bus.zero_q          = zero_q;
  assign bus.overflow_sticky = overflow_sticky;

endmodule

// File: tb/tb_mips_alu_datapath.sv
// Directed self-checking bench for mips_alu_datapath.
module tb_mips_alu_datapath;

  logic clock;
  logic reset;
  int   checks;
  int   fails;

  mips_alu_if #(.DATA_W(32), .REG_AW(5)) bus ();

  mips_alu_datapath #(.DATA_W(32), .REG_AW(5)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic ops(input logic [3:0] ctrl, input logic src,
                     input logic [31:0] rs, input logic [31:0] rt, input logic [31:0] imm);
    bus.alu_ctrl = ctrl;
    bus.alu_src  = src;
    bus.rs_data  = rs;
    bus.rt_data  = rt;
    bus.sign_ext = imm;
    #1;
  endtask

  task automatic flags(input string tag, input logic [31:0] res,
                       input logic c, input logic v, input logic z);
    chk({tag, "_result"}, bus.alu_result, res);
    chk({tag, "_carry"}, {31'd0, bus.carry}, {31'd0, c});
    chk({tag, "_ovf"}, {31'd0, bus.overflow}, {31'd0, v});
    chk({tag, "_zero"}, {31'd0, bus.zero}, {31'd0, z});
  endtask

  task automatic regs(input string tag, input logic c, input logic v,
                      input logic z, input logic s);
    chk({tag, "_carry_q"}, {31'd0, bus.carry_q}, {31'd0, c});
    chk({tag, "_ovf_q"}, {31'd0, bus.overflow_q}, {31'd0, v});
    chk({tag, "_zero_q"}, {31'd0, bus.zero_q}, {31'd0, z});
    chk({tag, "_sticky"}, {31'd0, bus.overflow_sticky}, {31'd0, s});
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    reset  = 1'b1;
    bus.status_we = 1'b0;
    bus.reg_dst   = 1'b0;
    bus.rt_addr   = 5'd0;
    bus.rd_addr   = 5'd0;
    ops(4'b0000, 1'b0, 32'h0, 32'h0, 32'h0);
    tick();
    tick();
    regs("rst", 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;

    // signed ADD overflow, then capture it
    ops(4'b0010, 1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h0);
    flags("add_ovf", 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    bus.status_we = 1'b1;
    tick();
    bus.status_we = 1'b0;
    regs("add_cap", 1'b0, 1'b1, 1'b0, 1'b1);

    ops(4'b0110, 1'b1, 32'h0000_0005, 32'h1234_5678, 32'h0000_0005);
    flags("sub_imm", 32'h0, 1'b1, 1'b0, 1'b1);
    ops(4'b0111, 1'b0, 32'h8000_0000, 32'h0000_0001, 32'h0);
    flags("slt_neg", 32'h1, 1'b1, 1'b0, 1'b0);
    ops(4'b0111, 1'b0, 32'h0000_0001, 32'h8000_0000, 32'h0);
    flags("slt_swap", 32'h0, 1'b0, 1'b0, 1'b1);
    ops(4'b0111, 1'b0, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0);
    flags("slt_ovf0", 32'h0, 1'b0, 1'b0, 1'b1);
    ops(4'b0111, 1'b0, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0);
    flags("slt_ovf1", 32'h1, 1'b1, 1'b0, 1'b0);

    bus.rt_addr = 5'd8;
    bus.rd_addr = 5'd31;
    bus.reg_dst = 1'b0;
    #1;
    chk("wreg_rt", {27'd0, bus.write_reg}, 32'd8);
    bus.reg_dst = 1'b1;
    #1;
    chk("wreg_rd", {27'd0, bus.write_reg}, 32'd31);

    ops(4'b0100, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0);
    flags("addu_c", 32'h0, 1'b1, 1'b0, 1'b1);
    bus.status_we = 1'b1;
    tick();
    bus.status_we = 1'b0;
    regs("addu_cap", 1'b1, 1'b0, 1'b1, 1'b1);

    ops(4'b0100, 1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h0);
    flags("addu_noovf", 32'h8000_0000, 1'b0, 1'b0, 1'b0);
    ops(4'b0010, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0);
    flags("add_neg", 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0);
    ops(4'b0000, 1'b0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h0);
    flags("and", 32'h00F0_00F0, 1'b0, 1'b0, 1'b0);
    ops(4'b0001, 1'b0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h0);
    flags("or", 32'hFFF0_FFF0, 1'b0, 1'b0, 1'b0);
    ops(4'b0011, 1'b0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h0);
    flags("xor", 32'hFF00_FF00, 1'b0, 1'b0, 1'b0);
    ops(4'b1100, 1'b0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h0);
    flags("nor", 32'h000F_000F, 1'b0, 1'b0, 1'b0);
    ops(4'b1001, 1'b1, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_1234);
    flags("lui", 32'h1234_0000, 1'b0, 1'b0, 1'b0);
    ops(4'b0101, 1'b0, 32'h0000_0001, 32'h0000_0002, 32'h0);
    flags("subu", 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
    ops(4'b0110, 1'b0, 32'h8000_0000, 32'h0000_0001, 32'h0);
    flags("sub_ovf", 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
    ops(4'b1111, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0);
    flags("unused", 32'h0, 1'b0, 1'b0, 1'b1);

    ops(4'b1000, 1'b0, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0);
`ifdef ALU_SLTU_EN
    flags("sltu", 32'h1, 1'b0, 1'b0, 1'b0);
`else
    flags("sltu_off", 32'h0, 1'b0, 1'b0, 1'b1);
`endif

    // reset beats status_we; combinational path still live under reset
    reset = 1'b1;
    bus.status_we = 1'b1;
    ops(4'b0010, 1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h0);
    flags("add_in_rst", 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    tick();
    regs("rst2", 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    bus.status_we = 1'b0;

    ops(4'b0010, 1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h0);
    tick();
    tick();
    regs("hold", 1'b0, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/mips_alu_datapath.md
Name: mips_alu_datapath

Overview:
- Execute-stage slice of the single-cycle MIPS core.
- Selects the ALU B operand (register rt or sign-extended immediate) and selects the destination register index (rt or rd).
- Performs the ALU operation combinationally and raises carry, overflow and zero flags.
- Holds a small clocked status register so flags can be inspected after the cycle.

Parameters:
- DATA_W, 32, operand/result width.
- REG_AW, 5, register-index width.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- alu_ctrl  in  4  operation select (encoding below).
- alu_src  in  1  0: B = rt_data; 1: B = sign_ext.
- reg_dst  in  1  0: write_reg = rt_addr; 1: write_reg = rd_addr.
- rs_data  in  DATA_W  operand A (R[rs]).
- rt_data  in  DATA_W  R[rt].
- sign_ext  in  DATA_W  sign-extended immediate.
- rt_addr  in  REG_AW  instruction[20:16].
- rd_addr  in  REG_AW  rd, or 31 for jal (resolved upstream).
- status_we  in  1  capture flags into status register this cycle.
- alu_result  out  DATA_W  combinational result.
- carry  out  1  combinational carry flag.
- overflow  out  1  combinational signed-overflow flag.
- zero  out  1  combinational, alu_result == 0.
- write_reg  out  REG_AW  combinational destination index.
- carry_q, overflow_q, zero_q  out  1 each  registered flags.
- overflow_sticky  out  1  set on any captured overflow.

Behaviour:
- Datapath is purely combinational, zero latency: B = alu_src ? sign_ext : rt_data; write_reg = reg_dst ? rd_addr : rt_addr.
- alu_ctrl encoding (A = rs_data):
  - 0000 AND
  - 0001 OR
  - 0010 ADD (signed)
  - 0011 XOR
  - 0100 ADDU
  - 0101 SUBU
  - 0110 SUB (signed)
  - 0111 SLT: signed A<B gives 1, else 0
  - 1001 LUI: B[15:0] shifted left by 16
  - 1100 NOR
  - all other codes: result 0, carry 0, overflow 0.
- carry:
  - ADD/ADDU: carry-out of bit DATA_W-1 of A+B.
  - SUB/SUBU/SLT: carry-out of A+~B+1, i.e. 1 when A>=B unsigned.
  - 0 for logic ops and LUI.
- overflow:
  - ADD: A and B share a sign and the result sign differs.
  - SUB: A and B differ in sign and the result sign differs from A.
  - 0 for all other ops.
  - SLT computes its comparison correctly even when A−B overflows (use sign of A−B XOR overflow).
- zero is computed from the final alu_result for every op, including unused codes (so zero=1 there).
- All arithmetic wraps modulo 2^DATA_W; the result is produced even when overflow=1.
- Status register:
  - Rising clock with reset=1: carry_q, overflow_q, zero_q, overflow_sticky all go to 0; reset has priority over status_we.
  - Rising clock with reset=0 and status_we=1: each *_q takes its combinational flag; overflow_sticky |= overflow.
  - Rising clock with status_we=0: all registered flags hold.
- Combinational outputs are independent of reset.

Optional Feature:
- Macro ALU_SLTU_EN.
- When defined: alu_ctrl 1000 = SLTU (unsigned A<B gives 1, else 0); carry as for SUB; overflow 0.
- When undefined: 1000 is treated as an unused code (result 0, all flags 0 except zero=1).

Decomposition:
- Shared package mips_alu_pkg holds:
  - alu_ctrl localparams: ALU_AND, ALU_OR, ALU_ADD, ALU_XOR, ALU_ADDU, ALU_SUBU, ALU_SUB, ALU_SLT, ALU_SLTU, ALU_LUI, ALU_NOR.
  - DATA_W/REG_AW defaults.
- One natural sub-module: mips_alu_core, the combinational ALU with flags.
- Both muxes and the status register stay in the top.

Test Plan:
- ADD: rs=0x7FFFFFFF, rt=1, alu_src=0 -> result 0x80000000, overflow=1, carry=0, zero=0; with status_we=1 the next edge gives overflow_q=1 and overflow_sticky=1.
- SUB with immediate: rs=5, sign_ext=0x00000005, alu_src=1 -> result 0, zero=1, carry=1, overflow=0.
- SLT: rs=0x80000000, rt=1 -> result 1; swap operands -> result 0.
- Mux select: reg_dst=0, rt_addr=8, rd_addr=31 -> write_reg=8; reg_dst=1 -> write_reg=31.
- Reset and hold:
  - Set overflow_sticky, then assert reset for one edge -> all registered flags 0.
  - With status_we=0, apply an overflowing ADD -> registered flags stay 0.
- ADDU carry: rs=0xFFFFFFFF, rt=1 -> result 0, carry=1, overflow=0, zero=1.
- Under ALU_SLTU_EN, SLTU: rs=1, rt=0xFFFFFFFF -> result 1.
